// File: rtl/serial_addsub_ctrl.sv
// Bit-serial N-bit adder/subtractor: streams operands LSB-first through one
// fas cell, recirculating the cell's carry/borrow through a flop each clock.

module fas (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);
    // Sum and difference share one XOR chain; only the carry/borrow term differs.
    assign s    = a ^ b ^ cin;
    assign cout = a_ns ? ((a & b) | (a & cin) | (b & cin))
                       : ((~a & b) | (~a & cin) | (b & cin));
endmodule

module serial_addsub_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         a_ns,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         carry_out,
    output logic         overflow
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   sa;
    logic [N-1:0]   sb;
    logic           op;
    logic           cin_q;
    logic [CW-1:0]  cnt;
    logic           cell_s;
    logic           cell_cout;

    fas u_fas (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (cin_q),
        .a_ns (op),
        .s    (cell_s),
        .cout (cell_cout)
    );

    // NOTE: all state lives in this one clocked block, so every assignment
    // is non-blocking; mixing in blocking writes would make the shift order
    // depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            op        <= 1'b0;
            cin_q     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= op_a;
                        sb    <= op_b;
                        op    <= a_ns;
                        cin_q <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (32'(cnt) >= N) begin
                        // Out-of-range count can only come from a forced upset.
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        sa     <= sa >> 1;
                        sb     <= sb >> 1;
                        result <= {cell_s, result[N-1:1]};
                        cin_q  <= cell_cout;
                        if (cnt == CW'(N - 1)) begin
                            // MSB bit-cycle: cin_q is the carry/borrow into the MSB.
                            carry_out <= cell_cout;
                            overflow  <= cin_q ^ cell_cout;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cnt       <= '0;
                            state     <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl (N=8): arithmetic vectors, latency,
// start-while-busy rejection and asynchronous mid-run reset.

module tb_serial_addsub_ctrl;
    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         a_ns;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         carry_out;
    logic         overflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    serial_addsub_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_ns      (a_ns),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one operation and wait (bounded) for done; inputs and samples at negedge.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic ns, input logic [7:0] exp_r,
                         input logic exp_c, input logic exp_v);
        int cycles;
        int busy_cycles;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        a_ns  = ns;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        busy_cycles = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cycles++;
            cycles++;
            @(negedge clk);
        end
        check({tag, "_latency"}, cycles, N);
        check({tag, "_busy_cycles"}, busy_cycles, N);
        check({tag, "_done"}, {31'd0, done}, 1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
        check({tag, "_result"}, {24'd0, result}, {24'd0, exp_r});
        check({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_c});
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_v});
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 0);
        check({tag, "_result_hold"}, {24'd0, result}, {24'd0, exp_r});
    endtask

    initial begin
        int dones;
        rst_n = 1'b0;
        start = 1'b0;
        a_ns  = 1'b1;
        op_a  = '0;
        op_b  = '0;

        #120;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_result", {24'd0, result}, 0);
        check("rst_carry", {31'd0, carry_out}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add_35_4a", 8'h35, 8'h4A, 1'b1, 8'h7F, 1'b0, 1'b0);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0);
        do_op("add_7f_01", 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1);
        do_op("sub_10_20", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
        do_op("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

        // Start again during RUN cycle 3 with different operands: must be ignored.
        @(negedge clk);
        op_a  = 8'h01;
        op_b  = 8'h02;
        a_ns  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        op_a  = 8'hAA;
        op_b  = 8'h55;
        a_ns  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 24; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("busy_start_dones", dones, 1);
        check("busy_start_result", {24'd0, result}, 32'h03);
        check("busy_start_idle", {31'd0, busy}, 0);

        // Asynchronous reset in RUN cycle 4.
        op_a  = 8'h11;
        op_b  = 8'h22;
        a_ns  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("midrun_busy_before", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("midrun_busy", {31'd0, busy}, 0);
        check("midrun_done", {31'd0, done}, 0);
        check("midrun_result", {24'd0, result}, 0);
        check("midrun_carry", {31'd0, carry_out}, 0);
        check("midrun_ovf", {31'd0, overflow}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {31'd0, busy}, 0);

        do_op("add_0f_01", 8'h0F, 8'h01, 1'b1, 8'h10, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial N-bit adder/subtractor controller.
- Shifts operands LSB-first into a single instance of the team's 1-bit full adder/subtractor cell (`fas`: a, b, cin, a_ns -> s, cout).
- Registers the cell's cout back into cin each clock and assembles the sum/difference in a result shift register.
- Sits directly upstream and downstream of `fas`: it feeds every cell input and consumes every cell output.

Parameters:
- N, 8, operand/result width in bits; legal range 2..32.
- CW, $clog2(N), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a_ns  input  1  operation select, latched with start: 1 = add, 0 = subtract (A - B).
- op_a  input  N  operand A, latched with start.
- op_b  input  N  operand B, latched with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result becomes valid.
- result  output  N  sum or difference; held until the next accepted start.
- carry_out  output  1  final cell cout: carry (add) or borrow (subtract).
- overflow  output  1  two's-complement signed overflow of the operation.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy, done, result, carry_out, overflow = 0.
  - Internal shift registers, counter and carry flop = 0.
  - Applies immediately, including mid-operation. The partial result is discarded, and the first edge after release starts in IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start = 1 at a clock edge: load sa <= op_a, sb <= op_b, op <= a_ns, cin_q <= 0, cnt <= 0. Go to RUN.
  - If start = 0: stay. Outputs hold.
- RUN (busy = 1):
  - Cell inputs: a = sa[0], b = sb[0], cin = cin_q, a_ns = op.
  - Each edge:
    - sa, sb shift right by one.
    - Result register shifts right with the cell's s entering at bit N-1.
    - cin_q <= cout.
    - cnt <= cnt + 1.
  - At the edge where cnt == N-1 (MSB bit-cycle):
    - carry_out <= cout.
    - overflow <= cin_q XOR cout (carry/borrow into MSB XOR carry/borrow out of MSB).
    - Go to DONE.
- DONE:
  - done = 1 for exactly this one cycle. busy = 0.
  - Next edge goes to IDLE unconditionally.
- Latency:
  - Start sampled at edge k; busy high over cycles k+1 .. k+N.
  - done high in cycle k+N+1.
  - Next start accepted at edge k+N+2 at the earliest.
- start is ignored while in RUN or DONE. It is not queued.
- Operands and a_ns are captured only at acceptance. Changes to op_a, op_b or a_ns during RUN have no effect.
- Arithmetic contract:
  - Add: result = (A + B) mod 2^N; carry_out = bit N of A + B.
  - Subtract: result = (A - B) mod 2^N; carry_out = 1 iff A < B unsigned.
  - Initial cin = 0 for both operations.
- Cell delays:
  - `fas` has non-zero propagation delays.
  - Clock period shall exceed the cell's worst-case a/b/cin-to-s/cout delay. The bench uses a period of 100 time units.
  - All state and outputs are registered; nothing is sampled combinationally from the cell except at clock edges.
- Counter:
  - Never wraps inside RUN. Cleared on acceptance.
  - Values ≥ N are unreachable and, if forced, go to IDLE.

Test Plan (N=8):
- Add 0x35 + 0x4A, a_ns=1 -> done at edge k+9 relative to start edge k; result=0x7F, carry_out=0, overflow=0; busy high exactly 8 cycles.
- Add 0xFF + 0x01 -> result=0x00, carry_out=1, overflow=0.
- Add 0x7F + 0x01 -> result=0x80, carry_out=0, overflow=1.
- Subtract 0x10 - 0x20, a_ns=0 -> result=0xF0, carry_out=1 (borrow), overflow=0.
- Subtract 0x80 - 0x01 -> result=0x7F, carry_out=0, overflow=1.
- Busy-start and mid-run reset:
  - Start 0x01+0x02, pulse start again at RUN cycle 3 with 0xAA/0x55 -> result=0x03 and exactly one done pulse.
  - Then start 0x11+0x22 and drop rst_n at RUN cycle 4 -> all outputs 0 immediately.
  - After release, start 0x0F+0x01 -> result=0x10.
